// File: rtl/g2e_pkg.sv
// Shared sizing helpers for the g2e width gearbox.
package g2e_pkg;

  function automatic int g2e_min_buffer_size(input int wr, input int rd);
    return wr + rd - 1;
  endfunction

  function automatic int g2e_level_width(input int size);
    return $clog2(size + 1);
  endfunction

  localparam int G2E_LEVEL_WIDTH = g2e_level_width(24);

endpackage

// File: rtl/g2e_gearbox.sv
// Packs WR_DATA_WIDTH-bit input words into RD_DATA_WIDTH-bit output words, LSB first,
// with valid/ready on both sides and a flush that zero-pads the final partial word.
module g2e_gearbox
  import g2e_pkg::*;
#(
  parameter int WR_DATA_WIDTH   = 8,
  parameter int RD_DATA_WIDTH   = 11,
  parameter int BUF_BUFFER_SIZE = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [WR_DATA_WIDTH-1:0]             wr_data,
  output logic                                 rd_valid,
  input  logic                                 rd_ready,
  output logic [RD_DATA_WIDTH-1:0]             rd_data,
  input  logic                                 flush,
  output logic [$clog2(BUF_BUFFER_SIZE+1)-1:0] level
);

  localparam int LW = g2e_level_width(BUF_BUFFER_SIZE);

  if (BUF_BUFFER_SIZE < g2e_min_buffer_size(WR_DATA_WIDTH, RD_DATA_WIDTH)) begin : g_size_check
    $error("g2e_gearbox: BUF_BUFFER_SIZE too small for WR_DATA_WIDTH + RD_DATA_WIDTH - 1");
  end

  logic [BUF_BUFFER_SIZE-1:0] buffer_q, buffer_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       flush_pending_q, flush_pending_d;
  logic                       wr_fire, rd_fire;
  logic [LW-1:0]              consumed;

  // Handshakes and masked output come from registered state only.
  always_comb begin
    wr_ready = !flush_pending_q && (level_q <= LW'(BUF_BUFFER_SIZE - WR_DATA_WIDTH));
    rd_valid = (level_q >= LW'(RD_DATA_WIDTH)) || (flush_pending_q && level_q != '0);
    for (int i = 0; i < RD_DATA_WIDTH; i++) begin
      rd_data[i] = buffer_q[i] & (int'(level_q) > i);
    end
    level = level_q;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_fire         = wr_valid & wr_ready;
    rd_fire         = rd_valid & rd_ready;
    consumed        = (level_q < LW'(RD_DATA_WIDTH)) ? level_q : LW'(RD_DATA_WIDTH);
    buffer_d        = buffer_q;
    level_d         = level_q;
    flush_pending_d = flush_pending_q;

    if (rd_fire) begin
      buffer_d = buffer_q >> RD_DATA_WIDTH;
      level_d  = level_q - consumed;
    end
    // After a read, level_d is already level - c, which is where the new word lands.
    if (wr_fire) begin
      buffer_d = buffer_d | (BUF_BUFFER_SIZE'(wr_data) << level_d);
      level_d  = level_d + LW'(WR_DATA_WIDTH);
    end

    if (level_d == '0) begin
      flush_pending_d = 1'b0;
    end else if (flush && !flush_pending_q && level_q != '0) begin
      flush_pending_d = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: buffer is reset too, because the masked rd_data and the OR-in write rely on zeroed upper bits.
      buffer_q        <= '0;
      level_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      buffer_q        <= buffer_d;
      level_q         <= level_d;
      flush_pending_q <= flush_pending_d;
    end
  end

endmodule

// File: tb/tb_g2e_gearbox.sv
// Self-checking bench for g2e_gearbox: bit-queue model compared every cycle plus literal checks.
module tb_g2e_gearbox;

  localparam int WR  = 8;
  localparam int RD  = 11;
  localparam int BUF = 24;
  localparam int LW  = $clog2(BUF + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WR-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [RD-1:0] rd_data;
  logic          flush = 1'b0;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  g2e_gearbox #(.WR_DATA_WIDTH(WR), .RD_DATA_WIDTH(RD), .BUF_BUFFER_SIZE(BUF)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .flush(flush), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the held bits as a queue, oldest first.
  bit mq[$];
  bit mpend = 1'b0;

  function automatic bit m_wr_ready();
    return !mpend && (mq.size() <= BUF - WR);
  endfunction

  function automatic bit m_rd_valid();
    return (mq.size() >= RD) || (mpend && mq.size() != 0);
  endfunction

  function automatic int m_rd_data();
    int v = 0;
    for (int i = 0; i < RD; i++) if (i < mq.size() && mq[i]) v |= (1 << i);
    return v;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      mq.delete();
      mpend = 1'b0;
    end else begin
      bit wf, rf;
      int sz;
      wf = wr_valid && m_wr_ready();
      rf = rd_valid_model_sample(rd_ready);
      sz = mq.size();
      if (rf) for (int i = 0; i < RD && mq.size() > 0; i++) void'(mq.pop_front());
      if (wf) for (int i = 0; i < WR; i++) mq.push_back(wr_data[i]);
      if (flush && sz != 0 && !mpend) mpend = 1'b1;
      if (mq.size() == 0) mpend = 1'b0;
    end
  end

  function automatic bit rd_valid_model_sample(input bit ready);
    return ready && m_rd_valid();
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("level", int'(level), mq.size());
      check("wr_ready", int'(wr_ready), int'(m_wr_ready()));
      check("rd_valid", int'(rd_valid), int'(m_rd_valid()));
      check("rd_data", int'(rd_data), m_rd_data());
      assert (level <= LW'(BUF)) else $error("level exceeds buffer size");
    end
  end

  task automatic step(input bit wv, input logic [WR-1:0] wd, input bit rr, input bit fl);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (rd_valid && guard < 50) begin
      step(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    check({name, "_drain_timeout"}, int'(guard < 50), 1);
  endtask

  initial begin
    // Reset
    do_reset();
    check("rst_level", int'(level), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);

    // Pack
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("pack1_rd_valid", int'(rd_valid), 0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("pack_level", int'(level), 16);
    check("pack_rd_valid", int'(rd_valid), 1);
    check("pack_rd_data", int'(rd_data), 'h4A5);
    step(1'b0, '0, 1'b0, 1'b0);
    check("pack_hold_rd_data", int'(rd_data), 'h4A5);
    step(1'b0, '0, 1'b1, 1'b0);
    check("read_level", int'(level), 5);
    check("read_rd_data", int'(rd_data), 'h007);
    check("read_rd_valid", int'(rd_valid), 0);

    // Simultaneous write and read at level 16
    do_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check("simul_level", int'(level), 13);
    check("simul_rd_data", int'(rd_data), 'h347);
    check("simul_rd_valid", int'(rd_valid), 1);

    // Backpressure
    do_reset();
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("bp2_level", int'(level), 16);
    check("bp2_wr_ready", int'(wr_ready), 1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("bp3_level", int'(level), 24);
    check("bp3_wr_ready", int'(wr_ready), 0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("bp4_level", int'(level), 24);
    check("bp4_rd_data", int'(rd_data), 'h7FF);

    // Flush of a partial word
    do_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("flush_rd_valid", int'(rd_valid), 1);
    check("flush_rd_data", int'(rd_data), 'h0A5);
    check("flush_wr_ready", int'(wr_ready), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_done_level", int'(level), 0);
    check("flush_done_wr_ready", int'(wr_ready), 1);
    check("flush_done_rd_valid", int'(rd_valid), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("flush_empty_ignored", int'(rd_valid), 0);

    // Reset mid-flush
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("mf_wr_ready", int'(wr_ready), 0);
    rst = 1'b1; flush = 1'b1; rd_ready = 1'b1; wr_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
    check("mf_level", int'(level), 0);
    check("mf_rd_valid", int'(rd_valid), 0);
    check("mf_wr_ready", int'(wr_ready), 1);

    // Streaming with intermittent backpressure, then a flush and drain (model-checked)
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 8'((i * 37 + 5) & 8'hFF), (i % 3) != 0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    drain("stream");
    check("stream_final_level", int'(level), 0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/g2e_gearbox.md
# g2e_gearbox

Parametrised single-clock width gearbox packing a stream of `WR_DATA_WIDTH`-bit words into `RD_DATA_WIDTH`-bit words, LSB-first, with valid/ready on both sides. Successor to the encoder-input width converter. Adds backpressure, occupancy reporting and a flush mode that zero-pads the final partial word. Sits between the byte-wide source and the Hamming encoder datapath.

## Interface

Parameters:

- `WR_DATA_WIDTH`, 8: input word width.
- `RD_DATA_WIDTH`, 11: output word width.
- `BUF_BUFFER_SIZE`, 24: buffer depth in bits. Must be ≥ `WR_DATA_WIDTH + RD_DATA_WIDTH - 1`; elaboration fails otherwise.

Ports (one clock; reset is synchronous and active-high):

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: `wr_data` valid.
- `wr_ready` out 1: gearbox accepts a write this cycle.
- `wr_data` in `WR_DATA_WIDTH`: input word.
- `rd_valid` out 1: `rd_data` valid.
- `rd_ready` in 1: consumer takes `rd_data` this cycle.
- `rd_data` out `RD_DATA_WIDTH`: output word, bit 0 is oldest.
- `flush` in 1: single-cycle request to emit remaining bits as a zero-padded word.
- `level` out `$clog2(BUF_BUFFER_SIZE+1)`: bits currently held.

## Operation

- State is the `buffer` register (`BUF_BUFFER_SIZE` bits), the `level` counter (0..`BUF_BUFFER_SIZE`) and the `flush_pending` flag.
- `wr_fire = wr_valid & wr_ready`. `rd_fire = rd_valid & rd_ready`.
- `wr_ready = !flush_pending && level <= BUF_BUFFER_SIZE - WR_DATA_WIDTH`. It depends on registered state only. There is no path from `rd_ready` to `wr_ready`.
- `rd_valid = level >= RD_DATA_WIDTH || (flush_pending && level != 0)`.
- `rd_data = buffer[RD_DATA_WIDTH-1:0]`. Bits at positions ≥ `level` are forced to 0.
- Consumed count `c` when `rd_fire`: `c = min(level, RD_DATA_WIDTH)`.
- Write only: `wr_data` is placed at `buffer[level +: WR]`, then `level += WR`.
- Read only: `buffer >>= RD`, then `level -= c`.
- Simultaneous write and read: `buffer = (buffer >> RD)` with `wr_data` placed at bit `level - c`, then `level += WR - c`.
- Vacated upper bits are zero.
- Flush:
  - `flush` with `level != 0` and `!flush_pending` sets `flush_pending`.
  - `flush` with `level == 0`, or while already pending, is ignored.
  - While pending, full words drain normally. The last partial word is presented zero-padded.
  - `flush_pending` clears on the cycle `level` becomes 0.
- Overflow and underflow cannot occur. Both are guarded by the ready/valid rules. An assertion in verification checks `level ≤ BUF_BUFFER_SIZE`.

## Timing

- Reset values: `level` = 0, `buffer` = 0, `flush_pending` = 0. Therefore `rd_valid` = 0, `rd_data` = 0 and `wr_ready` = 1.
- Reset mid-operation discards all held bits and any pending flush on the next edge.
- Latency: the first write that brings `level` ≥ RD is reflected in `rd_valid` the cycle after that write's edge.
- `rd_data` is combinational from registers and stable while `rd_valid && !rd_ready`.
- Throughput is limited by the slower side. With the defaults, steady state is 11 writes per 8 reads.
- A flush issued in cycle N raises `rd_valid` for a partial word in N+1 at the earliest.
- `rst` has priority over `flush`, `wr_fire` and `rd_fire` in the same cycle.

## Structure

- Shared package `g2e_pkg` holds:
  - function `g2e_min_buffer_size(wr, rd)`, which returns `wr + rd - 1`;
  - the `G2E_LEVEL_WIDTH` helper.
- No sub-module. The block is a single always_ff for `buffer`, `level` and `flush_pending`, plus an always_comb for the handshakes and the masked `rd_data`.

## Test plan

Defaults apply (8→11, size 24).

- Reset: hold `rst` 2 cycles → `level` = 0, `wr_ready` = 1, `rd_valid` = 0, `rd_data` = 0.
- Pack: write 0xA5, then 0x3C, with `rd_ready` = 0 → `level` = 16, `rd_valid` = 1, `rd_data` = 0x4A5. Then read → `level` = 5, `rd_data` = 0x007, `rd_valid` = 0.
- Backpressure: write 0xFF ×3 with `rd_ready` = 0 → after the 2nd write `level` = 16 and `wr_ready` = 1; after the 3rd write `level` = 24 and `wr_ready` = 0. A 4th `wr_valid` is not accepted and `level` stays 24.
- Simultaneous: at `level` = 16, assert `wr_valid` with 0x5A and `rd_ready` in the same cycle → `level` = 13. The new bits appear at `buffer[5 +: 8]`.
- Flush: from reset, write 0xA5, pulse `flush` → next cycle `rd_valid` = 1, `rd_data` = 0x0A5, `wr_ready` = 0. After the read, `level` = 0, `flush_pending` = 0 and `wr_ready` = 1.
- Reset mid-flush: `level` = 16, flush pending, assert `rst` → next cycle `level` = 0, `flush_pending` = 0, `rd_valid` = 0.
